// File: rtl/hs_adder.sv
// Lane-parallel half-adder stage: per-lane sum = a ^ b, carry = a & b.
// Optional output register with valid flag; combinational view always available.
module hs_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] sum_comb_o,
  output logic [WIDTH-1:0] carry_comb_o,
  output logic             carry_any_o
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
    assign sum_c[i]   = a_i[i] ^ b_i[i];
    assign carry_c[i] = a_i[i] & b_i[i];
  end

  assign sum_comb_o   = sum_c;
  assign carry_comb_o = carry_c;

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_d, sum_q;
    logic [WIDTH-1:0] carry_d, carry_q;
    logic             valid_d, valid_q;

    // Only capture when qualified so X on idle inputs never reaches the held result.
    always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = in_valid_i;
      if (in_valid_i) begin
        sum_d   = sum_c;
        carry_d = carry_c;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sum_q   <= '0;
        carry_q <= '0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    assign sum_o       = sum_q;
    assign carry_o     = carry_q;
    assign out_valid_o = valid_q;
    assign carry_any_o = valid_q & (|carry_q);
  end else begin : g_comb
    assign sum_o       = sum_c;
    assign carry_o     = carry_c;
    assign out_valid_o = in_valid_i;
    assign carry_any_o = in_valid_i & (|carry_c);
  end

  // A lane can never both generate and propagate.
  a_no_gen_and_prop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o |-> ((sum_o & carry_o) == '0));

endmodule

// File: tb/tb_hs_adder.sv
// Directed self-checking bench for hs_adder: registered 1- and 8-lane instances
// plus an 8-lane combinational instance.
module tb_hs_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // 8-lane registered
  logic       v8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8, c8, sc8, cc8;
  logic       ov8, any8;

  // 1-lane registered
  logic       v1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] s1, c1, sc1, cc1;
  logic       ov1, any1;

  // 8-lane combinational
  logic       vc = 1'b0;
  logic [7:0] ac = '0, bc = '0;
  logic [7:0] sco, cco, scc, ccc;
  logic       ovc, anyc;

  hs_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v8), .a_i(a8), .b_i(b8),
    .sum_o(s8), .carry_o(c8), .out_valid_o(ov8), .sum_comb_o(sc8),
    .carry_comb_o(cc8), .carry_any_o(any8)
  );

  hs_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v1), .a_i(a1), .b_i(b1),
    .sum_o(s1), .carry_o(c1), .out_valid_o(ov1), .sum_comb_o(sc1),
    .carry_comb_o(cc1), .carry_any_o(any1)
  );

  hs_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vc), .a_i(ac), .b_i(bc),
    .sum_o(sco), .carry_o(cco), .out_valid_o(ovc), .sum_comb_o(scc),
    .carry_comb_o(ccc), .carry_any_o(anyc)
  );

  task automatic test_reset();
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({s8, c8, ov8, any8} !== 18'h0)
      $display("FAIL reset_hold: got sum=%h carry=%h ov=%b any=%b, want all 0", s8, c8, ov8, any8);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (ov8 !== 1'b0) $display("FAIL reset_release_pre_edge: got ov=%b want 0", ov8);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (s8 !== 8'h00 || c8 !== 8'hFF || ov8 !== 1'b1 || any8 !== 1'b1)
      $display("FAIL reset_release: got sum=%h carry=%h ov=%b any=%b, want 00 FF 1 1",
               s8, c8, ov8, any8);
    else n_pass++;
  endtask

  task automatic test_truth_table();
    logic [3:0] exp_s;
    logic [3:0] exp_c;
    logic [1:0] ab;
    exp_s = 4'b0110;
    exp_c = 4'b1000;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      ab = 2'(v);
      v1 = 1'b1; a1 = ab[1]; b1 = ab[0];
      @(posedge clk); #1;
      n_total++;
      if (s1[0] !== exp_s[v] || c1[0] !== exp_c[v] || ov1 !== 1'b1 || any1 !== exp_c[v])
        $display("FAIL truth_ab%0d: got s=%b c=%b ov=%b any=%b, want s=%b c=%b ov=1 any=%b",
                 v, s1, c1, ov1, any1, exp_s[v], exp_c[v], exp_c[v]);
      else n_pass++;
    end
  endtask

  task automatic test_comb();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] es [4];
    logic [7:0] ec [4];
    va = '{8'h00, 8'hA5, 8'hFF, 8'h3C};
    vb = '{8'h00, 8'h0F, 8'hFF, 8'h33};
    es = '{8'h00, 8'hAA, 8'h00, 8'h0F};
    ec = '{8'h00, 8'h05, 8'hFF, 8'h30};
    for (int i = 0; i < 4; i++) begin
      #5;
      vc = i[0]; ac = va[i]; bc = vb[i];
      #1;
      n_total++;
      if (sco !== es[i] || cco !== ec[i] || scc !== es[i] || ccc !== ec[i] ||
          ovc !== i[0] || anyc !== (i[0] & (|ec[i])))
        $display("FAIL comb_%0d: got s=%h c=%h sc=%h cc=%h ov=%b any=%b, want s=%h c=%h ov=%b any=%b",
                 i, sco, cco, scc, ccc, ovc, anyc, es[i], ec[i], i[0], i[0] & (|ec[i]));
      else n_pass++;
    end
  endtask

  task automatic test_multi_lane();
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
    @(posedge clk); #1;
    n_total++;
    if (s8 !== 8'h3C || c8 !== 8'hC0 || any8 !== 1'b1 || ov8 !== 1'b1)
      $display("FAIL lanes_f0_cc: got s=%h c=%h any=%b ov=%b, want 3c c0 1 1", s8, c8, any8, ov8);
    else n_pass++;
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'hF0;
    @(posedge clk); #1;
    n_total++;
    if (s8 !== 8'hFF || c8 !== 8'h00 || any8 !== 1'b0 || ov8 !== 1'b1)
      $display("FAIL lanes_0f_f0: got s=%h c=%h any=%b ov=%b, want ff 00 0 1", s8, c8, any8, ov8);
    else n_pass++;
  endtask

  task automatic test_hold();
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (ov1 !== 1'b0 || s1 !== 1'b0 || c1 !== 1'b1 || sc1 !== 1'b1 || any1 !== 1'b0)
      $display("FAIL hold: got ov=%b s=%b c=%b sc=%b any=%b, want 0 0 1 1 0",
               ov1, s1, c1, sc1, any1);
    else n_pass++;
    @(negedge clk);
    a1 = 1'bx; b1 = 1'bz;
    @(posedge clk); #1;
    n_total++;
    if (ov1 !== 1'b0 || s1 !== 1'b0 || c1 !== 1'b1)
      $display("FAIL hold_x: got ov=%b s=%b c=%b, want 0 0 1", ov1, s1, c1);
    else n_pass++;
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra, rb;
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h5A; b8 = 8'h0F;
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h81;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({s8, c8, ov8, any8} !== 18'h0)
      $display("FAIL midstream_reset: got s=%h c=%h ov=%b any=%b, want all 0", s8, c8, ov8, any8);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    v8 = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (ov8 !== 1'b0 || s8 !== 8'h00 || c8 !== 8'h00)
      $display("FAIL post_reset_idle: got ov=%b s=%h c=%h, want 0 00 00", ov8, s8, c8);
    else n_pass++;
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hAA; b8 = 8'hFF;
    @(posedge clk); #1;
    n_total++;
    if (ov8 !== 1'b1 || s8 !== 8'h55 || c8 !== 8'hAA || any8 !== 1'b1)
      $display("FAIL post_reset_first: got ov=%b s=%h c=%h any=%b, want 1 55 aa 1",
               ov8, s8, c8, any8);
    else n_pass++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom);
      a8 = ra; b8 = rb;
      @(posedge clk); #1;
      n_total++;
      if (s8 !== (ra ^ rb) || c8 !== (ra & rb) || (s8 & c8) !== 8'h00 || ov8 !== 1'b1 ||
          any8 !== (|(ra & rb)))
        $display("FAIL random_%0d: a=%h b=%h got s=%h c=%h ov=%b any=%b", i, ra, rb, s8, c8,
                 ov8, any8);
      else n_pass++;
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_comb();
    test_multi_lane();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
